// File: rtl/dem_ngay_thang_nam_pkg.sv
// Shared constants and BCD helpers for the day/month/year calendar counter.
package dem_ngay_thang_nam_pkg;

    localparam logic [2:0] MODE_SET_NGAY  = 3'b011;
    localparam logic [2:0] MODE_SET_THANG = 3'b100;
    localparam logic [2:0] MODE_SET_NAM   = 3'b101;

    localparam logic [7:0]  RST_NGAY  = 8'h01;
    localparam logic [7:0]  RST_THANG = 8'h01;
    localparam logic [15:0] RST_NAM   = 16'h2000;

    localparam logic [7:0] THANG_01 = 8'h01;
    localparam logic [7:0] THANG_02 = 8'h02;
    localparam logic [7:0] THANG_04 = 8'h04;
    localparam logic [7:0] THANG_06 = 8'h06;
    localparam logic [7:0] THANG_09 = 8'h09;
    localparam logic [7:0] THANG_11 = 8'h11;
    localparam logic [7:0] THANG_12 = 8'h12;

    localparam logic [7:0] NGAY_01 = 8'h01;
    localparam logic [7:0] NGAY_28 = 8'h28;
    localparam logic [7:0] NGAY_29 = 8'h29;
    localparam logic [7:0] NGAY_30 = 8'h30;
    localparam logic [7:0] NGAY_31 = 8'h31;

    localparam logic [7:0] GIAY_MAX = 8'h59;
    localparam logic [7:0] PHUT_MAX = 8'h59;
    localparam logic [7:0] GIO_MAX  = 8'h23;

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (v[15:12] == 4'd9) ? 4'd0 : v[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd9;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = (v[15:12] == 4'd0) ? 4'd9 : v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Two-digit BCD divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
    function automatic logic bcd2_div4(input logic [7:0] v);
        if (!v[4])
            return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
        else
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    endfunction

endpackage

// File: rtl/dem_ngay_thang_nam_so_ngay_toi_da.sv
// Days-in-month and leap-year flag, computed directly on BCD digits.
module so_ngay_toi_da
    import dem_ngay_thang_nam_pkg::*;
(
    input  logic [7:0]  thang,
    input  logic [15:0] nam,
    output logic [7:0]  max_day,
    output logic        nam_nhuan
);

    // Century years fall back to the century digits, giving the mod-400 rule.
    assign nam_nhuan = (nam[7:0] == 8'h00) ? bcd2_div4(nam[15:8]) : bcd2_div4(nam[7:0]);

    always_comb begin
        case (thang)
            THANG_04, THANG_06, THANG_09, THANG_11: max_day = NGAY_30;
            THANG_02:                               max_day = nam_nhuan ? NGAY_29 : NGAY_28;
            default:                                max_day = NGAY_31;
        endcase
    end

endmodule

// File: rtl/dem_ngay_thang_nam.sv
// Calendar day/month/year counter with midnight rollover and button-driven set modes.
module dem_ngay_thang_nam
    import dem_ngay_thang_nam_pkg::*;
(
    input  logic        clk_1Hz,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [2:0]  mode,
    input  logic [7:0]  giay,
    input  logic [7:0]  phut,
    input  logic [7:0]  gio,
    output logic [7:0]  ngay,
    output logic [7:0]  thang,
    output logic [15:0] nam,
    output logic        nam_nhuan
);

    logic [2:0]  mode_dec;
    logic        up;
    logic        down;
    logic        rollover;
    logic [7:0]  max_cur;
    logic [7:0]  max_next;
    logic        nhuan_next_unused;
    logic [7:0]  ngay_n;
    logic [7:0]  thang_n;
    logic [15:0] nam_n;
    logic [7:0]  ngay_d;

    assign mode_dec = ~mode;
    assign up       = ~btn_up;
    assign down     = ~btn_down;
    assign rollover = (gio == GIO_MAX) && (phut == PHUT_MAX) && (giay == GIAY_MAX);

    so_ngay_toi_da u_cur (
        .thang     (thang),
        .nam       (nam),
        .max_day   (max_cur),
        .nam_nhuan (nam_nhuan)
    );

    // Limit for the candidate month/year, used to clamp the day on the same edge.
    so_ngay_toi_da u_next (
        .thang     (thang_n),
        .nam       (nam_n),
        .max_day   (max_next),
        .nam_nhuan (nhuan_next_unused)
    );

    always_comb begin
        ngay_n  = ngay;
        thang_n = thang;
        nam_n   = nam;
        case (mode_dec)
            MODE_SET_NGAY: begin
                if (up)
                    ngay_n = (ngay >= max_cur) ? NGAY_01 : bcd2_inc(ngay);
                else if (down)
                    ngay_n = (ngay <= NGAY_01) ? max_cur : bcd2_dec(ngay);
            end
            MODE_SET_THANG: begin
                if (up)
                    thang_n = (thang == THANG_12) ? THANG_01 : bcd2_inc(thang);
                else if (down)
                    thang_n = (thang == THANG_01) ? THANG_12 : bcd2_dec(thang);
            end
            MODE_SET_NAM: begin
                if (up)
                    nam_n = bcd4_inc(nam);
                else if (down)
                    nam_n = bcd4_dec(nam);
            end
            default: begin
                if (rollover) begin
                    if (ngay < max_cur) begin
                        ngay_n = bcd2_inc(ngay);
                    end else begin
                        ngay_n = NGAY_01;
                        if (thang == THANG_12) begin
                            thang_n = THANG_01;
                            nam_n   = bcd4_inc(nam);
                        end else begin
                            thang_n = bcd2_inc(thang);
                        end
                    end
                end
            end
        endcase
        ngay_d = (ngay_n > max_next) ? max_next : ngay_n;
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            ngay  <= RST_NGAY;
            thang <= RST_THANG;
            nam   <= RST_NAM;
        end else begin
            ngay  <= ngay_d;
            thang <= thang_n;
            nam   <= nam_n;
        end
    end

endmodule

// File: tb/tb_dem_ngay_thang_nam.sv
// Self-checking bench for dem_ngay_thang_nam against an integer calendar model.
module tb_dem_ngay_thang_nam;

    localparam logic [2:0] M_RUN   = 3'b000;
    localparam logic [2:0] M_NGAY  = 3'b011;
    localparam logic [2:0] M_THANG = 3'b100;
    localparam logic [2:0] M_NAM   = 3'b101;

    logic        clk_1Hz = 1'b0;
    logic        rst_n;
    logic        btn_up;
    logic        btn_down;
    logic [2:0]  mode;
    logic [7:0]  giay;
    logic [7:0]  phut;
    logic [7:0]  gio;
    logic [7:0]  ngay;
    logic [7:0]  thang;
    logic [15:0] nam;
    logic        nam_nhuan;

    int n_cmp = 0;
    int n_bad = 0;
    int m_d;
    int m_m;
    int m_y;

    typedef struct {
        logic [2:0]  md;
        logic        up;
        logic        dn;
        logic        roll;
        logic [7:0]  e_ngay;
        logic [7:0]  e_thang;
        logic [15:0] e_nam;
        logic        e_nhuan;
    } vec_t;

    vec_t tbl[17];

    dem_ngay_thang_nam dut (
        .clk_1Hz   (clk_1Hz),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .mode      (mode),
        .giay      (giay),
        .phut      (phut),
        .gio       (gio),
        .ngay      (ngay),
        .thang     (thang),
        .nam       (nam),
        .nam_nhuan (nam_nhuan)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    function automatic bit leap(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int mdays(input int m, input int y);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return leap(y) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [32:0] model_vec();
        return {to_bcd2(m_d), to_bcd2(m_m), to_bcd4(m_y), leap(m_y)};
    endfunction

    task automatic model_reset();
        m_d = 1;
        m_m = 1;
        m_y = 2000;
    endtask

    task automatic model_step(input logic [2:0] md, input logic up, input logic dn, input logic roll);
        int lim;
        lim = mdays(m_m, m_y);
        case (md)
            M_NGAY: begin
                if (up)      m_d = (m_d == lim) ? 1 : m_d + 1;
                else if (dn) m_d = (m_d == 1) ? lim : m_d - 1;
            end
            M_THANG: begin
                if (up)      m_m = m_m % 12 + 1;
                else if (dn) m_m = (m_m + 10) % 12 + 1;
            end
            M_NAM: begin
                if (up)      m_y = (m_y + 1) % 10000;
                else if (dn) m_y = (m_y + 9999) % 10000;
            end
            default: begin
                if (roll) begin
                    if (m_d < lim) begin
                        m_d = m_d + 1;
                    end else begin
                        m_d = 1;
                        if (m_m == 12) begin
                            m_m = 1;
                            m_y = (m_y + 1) % 10000;
                        end else begin
                            m_m = m_m + 1;
                        end
                    end
                end
            end
        endcase
        if (m_d > mdays(m_m, m_y)) m_d = mdays(m_m, m_y);
    endtask

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ngay/thang/nam/nhuan=%h/%h/%h/%b required %h/%h/%h/%b",
                     name, got[32:25], got[24:17], got[16:1], got[0],
                     exp[32:25], exp[24:17], exp[16:1], exp[0]);
        end
    endtask

    task automatic drive(input logic [2:0] md, input logic up, input logic dn, input logic roll);
        int g;
        int p;
        int s;
        mode     = ~md;
        btn_up   = ~up;
        btn_down = ~dn;
        if (roll) begin
            gio  = 8'h23;
            phut = 8'h59;
            giay = 8'h59;
        end else begin
            g = $urandom_range(0, 23);
            p = $urandom_range(0, 59);
            s = $urandom_range(0, 59);
            if (g == 23 && p == 59 && s == 59) s = 58;
            gio  = to_bcd2(g);
            phut = to_bcd2(p);
            giay = to_bcd2(s);
        end
    endtask

    task automatic step(input logic [2:0] md, input logic up, input logic dn, input logic roll,
                        input string name);
        drive(md, up, dn, roll);
        @(posedge clk_1Hz);
        model_step(md, up, dn, roll);
        @(negedge clk_1Hz);
        chk(name, {ngay, thang, nam, nam_nhuan}, model_vec());
    endtask

    task automatic goto_date(input int d, input int m, input int y);
        int diff;
        diff = (y - m_y + 10000) % 10000;
        for (int i = 0; i < 10000 && m_y != y; i++) step(M_NAM, diff <= 5000, diff > 5000, 1'b0, "goto_nam");
        for (int i = 0; i < 12 && m_m != m; i++) step(M_THANG, 1'b1, 1'b0, 1'b0, "goto_thang");
        for (int i = 0; i < 31 && m_d != d; i++) step(M_NGAY, 1'b1, 1'b0, 1'b0, "goto_ngay");
    endtask

    initial begin
        tbl[0]  = '{M_RUN,   1'b0, 1'b0, 1'b1, 8'h02, 8'h01, 16'h2000, 1'b1};
        tbl[1]  = '{3'b001,  1'b0, 1'b0, 1'b0, 8'h02, 8'h01, 16'h2000, 1'b1};
        tbl[2]  = '{M_NGAY,  1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 16'h2000, 1'b1};
        tbl[3]  = '{M_NGAY,  1'b0, 1'b1, 1'b0, 8'h31, 8'h01, 16'h2000, 1'b1};
        tbl[4]  = '{M_NGAY,  1'b0, 1'b0, 1'b1, 8'h31, 8'h01, 16'h2000, 1'b1};
        tbl[5]  = '{M_THANG, 1'b1, 1'b0, 1'b0, 8'h29, 8'h02, 16'h2000, 1'b1};
        tbl[6]  = '{M_NAM,   1'b1, 1'b0, 1'b0, 8'h28, 8'h02, 16'h2001, 1'b0};
        tbl[7]  = '{M_RUN,   1'b0, 1'b0, 1'b1, 8'h01, 8'h03, 16'h2001, 1'b0};
        tbl[8]  = '{M_THANG, 1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 16'h2001, 1'b0};
        tbl[9]  = '{M_NGAY,  1'b0, 1'b1, 1'b0, 8'h28, 8'h02, 16'h2001, 1'b0};
        tbl[10] = '{M_THANG, 1'b1, 1'b1, 1'b0, 8'h28, 8'h03, 16'h2001, 1'b0};
        tbl[11] = '{M_NAM,   1'b0, 1'b1, 1'b0, 8'h28, 8'h03, 16'h2000, 1'b1};
        tbl[12] = '{3'b111,  1'b0, 1'b0, 1'b1, 8'h29, 8'h03, 16'h2000, 1'b1};
        tbl[13] = '{M_RUN,   1'b1, 1'b0, 1'b0, 8'h29, 8'h03, 16'h2000, 1'b1};
        tbl[14] = '{M_THANG, 1'b0, 1'b1, 1'b0, 8'h29, 8'h02, 16'h2000, 1'b1};
        tbl[15] = '{M_NAM,   1'b0, 1'b1, 1'b0, 8'h28, 8'h02, 16'h1999, 1'b0};
        tbl[16] = '{M_RUN,   1'b0, 1'b0, 1'b1, 8'h01, 8'h03, 16'h1999, 1'b0};

        rst_n = 1'b0;
        drive(M_RUN, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        chk("reset_state", {ngay, thang, nam, nam_nhuan}, {8'h01, 8'h01, 16'h2000, 1'b1});
        @(negedge clk_1Hz);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].md, tbl[i].up, tbl[i].dn, tbl[i].roll, $sformatf("tbl_model_%0d", i));
            chk($sformatf("tbl_row_%0d", i), {ngay, thang, nam, nam_nhuan},
                {tbl[i].e_ngay, tbl[i].e_thang, tbl[i].e_nam, tbl[i].e_nhuan});
        end

        goto_date(28, 2, 1900);
        step(M_RUN, 1'b0, 1'b0, 1'b1, "roll_1900");
        chk("feb28_1900", {ngay, thang, nam, nam_nhuan}, {8'h01, 8'h03, 16'h1900, 1'b0});
        goto_date(28, 2, 2000);
        step(M_RUN, 1'b0, 1'b0, 1'b1, "roll_2000");
        chk("feb28_2000", {ngay, thang, nam, nam_nhuan}, {8'h29, 8'h02, 16'h2000, 1'b1});

        goto_date(31, 12, 9999);
        step(M_RUN, 1'b0, 1'b0, 1'b1, "roll_9999");
        chk("wrap_9999", {ngay, thang, nam, nam_nhuan}, {8'h01, 8'h01, 16'h0000, 1'b1});

        goto_date(31, 3, 2024);
        step(M_NGAY, 1'b1, 1'b0, 1'b0, "day_up_31");
        chk("day_wrap_31", {ngay, thang, nam, nam_nhuan}, {8'h01, 8'h03, 16'h2024, 1'b1});
        step(M_NGAY, 1'b0, 1'b0, 1'b1, "set_no_roll");
        chk("set_suppress", {ngay, thang, nam, nam_nhuan}, {8'h01, 8'h03, 16'h2024, 1'b1});

        // The clamp to 30 in April is kept when stepping back to March.
        goto_date(31, 5, 2023);
        step(M_THANG, 1'b0, 1'b1, 1'b0, "mon_dn_1");
        chk("clamp_apr", {ngay, thang, nam, nam_nhuan}, {8'h30, 8'h04, 16'h2023, 1'b0});
        step(M_THANG, 1'b0, 1'b1, 1'b0, "mon_dn_2");
        chk("clamp_mar", {ngay, thang, nam, nam_nhuan}, {8'h30, 8'h03, 16'h2023, 1'b0});
        step(M_THANG, 1'b0, 1'b1, 1'b0, "mon_dn_3");
        chk("clamp_feb", {ngay, thang, nam, nam_nhuan}, {8'h28, 8'h02, 16'h2023, 1'b0});
        step(M_NAM, 1'b1, 1'b0, 1'b0, "yr_up_2024");
        chk("year_2024", {ngay, thang, nam, nam_nhuan}, {8'h28, 8'h02, 16'h2024, 1'b1});

        goto_date(28, 2, 2099);
        step(M_NAM, 1'b1, 1'b1, 1'b0, "both_2099");
        chk("both_up_prio", {ngay, thang, nam, nam_nhuan}, {8'h28, 8'h02, 16'h2100, 1'b0});
        drive(M_NAM, 1'b1, 1'b1, 1'b0);
        @(posedge clk_1Hz);
        model_step(M_NAM, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {ngay, thang, nam, nam_nhuan}, {8'h01, 8'h01, 16'h2000, 1'b1});
        model_reset();
        @(posedge clk_1Hz);
        #1;
        chk("reset_hold", {ngay, thang, nam, nam_nhuan}, {8'h01, 8'h01, 16'h2000, 1'b1});
        @(negedge clk_1Hz);
        rst_n = 1'b1;
        step(M_RUN, 1'b0, 1'b0, 1'b1, "after_reset");
        chk("after_reset_roll", {ngay, thang, nam, nam_nhuan}, {8'h02, 8'h01, 16'h2000, 1'b1});

        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] md;
            logic [2:0] run_codes [5];
            run_codes = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
            r = $urandom_range(0, 9);
            if (r < 4)      md = run_codes[$urandom_range(0, 4)];
            else if (r < 6) md = M_NGAY;
            else if (r < 8) md = M_THANG;
            else            md = M_NAM;
            step(md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
